// File: rtl/parameters_pkg.sv
// rtl/parameters_pkg.sv - shared constants and state type for the UART receive path
//
// Purpose : frame geometry (prescale counter width, data bits per frame),
//           legal oversampling ratios and the receive FSM state type.
// Ports   : none (package).
package parameters_pkg;

   localparam int PRESCALE_W = 6;
   localparam int DATA_W     = 8;
   localparam int BIT_CNT_W  = $clog2(DATA_W);

   localparam logic [PRESCALE_W-1:0] PRESCALE_8  = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] PRESCALE_16 = PRESCALE_W'(16);
   localparam logic [PRESCALE_W-1:0] PRESCALE_32 = PRESCALE_W'(32);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter and bit counter for the UART receiver
//
// Purpose : counts oversample edges 0..P-1 within a bit and bits 0..DATA_W-1
//           within a state. P is the Prescale value captured when a frame
//           starts, so a Prescale change mid-frame has no effect.
// Ports   :
//   CLK, RST        clock, asynchronous active-low reset
//   load_prescale   capture Prescale (asserted on the start-bit detect cycle)
//   Prescale        oversampling ratio
//   cnt_en          count enable (frame states only)
//   cnt_clr         clear both counters (asserted on every state change)
//   edge_cnt        oversample index within the current bit
//   bit_cnt         bit index within the current state
//   edge_last       edge_cnt is at P-1 (bit decision point)
module uart_rx_edge_bit_cnt
   import parameters_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load_prescale,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  cnt_en,
   input  logic                  cnt_clr,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  edge_last
);

   logic [PRESCALE_W-1:0] prescale_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         prescale_q <= '0;
      end else if (load_prescale) begin
         prescale_q <= Prescale;
      end
   end

   assign edge_last = (edge_cnt == prescale_q - PRESCALE_W'(1));

   // Clear has priority over counting so that each new state starts at edge 0.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (cnt_clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (cnt_en) begin
         if (edge_last) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt == BIT_CNT_W'(DATA_W - 1)) ? '0 : bit_cnt + BIT_CNT_W'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-path controller (frame FSM, deserializer, error checks)
//
// Purpose : detects the start edge, sequences start / DATA_W data bits
//           (LSB first) / optional parity / stop, drives the sampler's edge
//           counter and enable, deserializes sampled_bit and reports the byte
//           with a one-cycle data_valid strobe. par_err / stp_err describe the
//           last frame and clear when the next start bit is detected.
// Config  : define UART_RX_ERR_CNT_EN to add the saturating err_cnt output.
// Ports   :
//   CLK, RST      oversampling clock, asynchronous active-low reset
//   RX_IN         synchronized serial line, idle high
//   Prescale      oversampling ratio (8, 16 or 32)
//   PAR_EN        parity bit present
//   PAR_TYP       0 = even, 1 = odd parity
//   sampled_bit   majority-voted bit from the sampler
//   data_samp_en  sampler enable
//   edge_cnt      oversample index within the current bit
//   P_DATA        last good received byte
//   data_valid    one-cycle strobe for a good frame
//   par_err       parity error of the last frame
//   stp_err       stop error of the last frame
//   err_cnt       (optional) saturating count of bad frames and start glitches
module uart_rx_ctrl
   import parameters_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled_bit,
   output logic                  data_samp_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [DATA_W-1:0]     P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
`ifdef UART_RX_ERR_CNT_EN
   ,
   output logic [7:0]            err_cnt
`endif
);

   rx_state_e             state, state_next;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  edge_last;
   logic                  cnt_en;
   logic                  start_entry;
   logic                  start_glitch;
   logic [DATA_W-1:0]     shift_q;

   assign cnt_en       = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);
   assign start_entry  = (state == IDLE) && !RX_IN;
   assign start_glitch = (state == START) && edge_last && sampled_bit;

   uart_rx_edge_bit_cnt u_cnt (
      .CLK           (CLK),
      .RST           (RST),
      .load_prescale (start_entry),
      .Prescale      (Prescale),
      .cnt_en        (cnt_en),
      .cnt_clr       (state_next != state),
      .edge_cnt      (edge_cnt),
      .bit_cnt       (bit_cnt),
      .edge_last     (edge_last)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      data_samp_en = cnt_en;
      data_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (!RX_IN) state_next = START;
         end
         START: begin
            if (edge_last) state_next = sampled_bit ? IDLE : DATA;
         end
         DATA: begin
            if (edge_last && (bit_cnt == BIT_CNT_W'(DATA_W - 1))) begin
               state_next = PAR_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (edge_last) state_next = STOP;
         end
         STOP: begin
            if (edge_last) state_next = DONE;
         end
         DONE: begin
            data_valid = !par_err && !stp_err;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // P_DATA is loaded on the STOP -> DONE transition of a good frame so the
   // new byte is already on P_DATA during the DONE cycle that strobes
   // data_valid; a bad frame leaves the previous byte in place.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shift_q <= '0;
         P_DATA  <= '0;
         par_err <= 1'b0;
         stp_err <= 1'b0;
      end else begin
         if (start_entry) begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
         end
         if ((state == DATA) && edge_last) begin
            shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
         end
         if ((state == PARITY) && edge_last) begin
            par_err <= (sampled_bit != (^shift_q ^ PAR_TYP));
         end
         if ((state == STOP) && edge_last) begin
            stp_err <= ~sampled_bit;
            if (sampled_bit && !par_err) begin
               P_DATA <= shift_q;
            end
         end
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_cnt <= '0;
      end else if ((((state == DONE) && (par_err || stp_err)) || start_glitch) &&
                   (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
   import parameters_pkg::*;

   logic                  CLK = 1'b0;
   logic                  RST = 1'b0;
   logic                  RX_IN = 1'b1;
   logic [PRESCALE_W-1:0] Prescale = PRESCALE_8;
   logic                  PAR_EN = 1'b0;
   logic                  PAR_TYP = 1'b0;
   logic                  sampled_bit;
   logic                  data_samp_en;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [DATA_W-1:0]     P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0]            err_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   uart_rx_ctrl dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .Prescale     (Prescale),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .sampled_bit  (sampled_bit),
      .data_samp_en (data_samp_en),
      .edge_cnt     (edge_cnt),
      .P_DATA       (P_DATA),
      .data_valid   (data_valid),
      .par_err      (par_err),
      .stp_err      (stp_err)
`ifdef UART_RX_ERR_CNT_EN
      ,
      .err_cnt      (err_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   // Majority-vote sampler: three samples centred at P/2-1.
   int         cur_p = 8;
   logic [2:0] win = 3'b111;
   always @(posedge CLK) begin
      if (data_samp_en) begin
         if (int'(edge_cnt) == cur_p / 2 - 2) win[0] <= RX_IN;
         if (int'(edge_cnt) == cur_p / 2 - 1) win[1] <= RX_IN;
         if (int'(edge_cnt) == cur_p / 2)     win[2] <= RX_IN;
      end
   end
   assign sampled_bit = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);

   // Capture every data_valid pulse and its byte.
   logic [7:0] got_q[$];
   int         vrun = 0;
   int         max_run = 0;
   always @(negedge CLK) begin
      if (data_valid) begin
         got_q.push_back(P_DATA);
         vrun = vrun + 1;
         if (vrun > max_run) max_run = vrun;
      end else begin
         vrun = 0;
      end
   end

   // Reference model of frame outcomes.
   logic [7:0] exp_pdata = 8'h00;
   logic       exp_par = 1'b0;
   logic       exp_stp = 1'b0;
   logic       exp_good = 1'b0;
   int         exp_err_cnt = 0;

   task automatic model_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stopb);
      logic ok_par;
      ok_par   = ((^d) ^ ptyp) == pbit;
      exp_par  = pen && !ok_par;
      exp_stp  = !stopb;
      exp_good = !exp_par && !exp_stp;
      if (exp_good) exp_pdata = d;
      else if (exp_err_cnt < 255) exp_err_cnt = exp_err_cnt + 1;
   endtask

   task automatic drive_bit(input logic v, input int p);
      RX_IN = v;
      repeat (p) @(negedge CLK);
   endtask

   // Everything after the start bit; Prescale is scrambled here because the
   // receiver must keep using the ratio it latched at the start edge.
   task automatic drive_payload(input logic [7:0] d, input int p, input logic pen,
                                input logic pbit, input logic stopb);
      logic [PRESCALE_W-1:0] legal [3];
      legal = '{PRESCALE_8, PRESCALE_16, PRESCALE_32};
      Prescale = legal[$urandom_range(0, 2)];
      for (int i = 0; i < DATA_W; i++) drive_bit(d[i], p);
      if (pen) drive_bit(pbit, p);
      drive_bit(stopb, p);
   endtask

   task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                             input logic ptyp, input logic pbit, input logic stopb);
      Prescale = PRESCALE_W'(p);
      cur_p    = p;
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      drive_bit(1'b0, p);
      drive_payload(d, p, pen, pbit, stopb);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
      n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_p_data: got %h want 00", P_DATA); end
      n_vec++; if ({par_err, stp_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {par_err, stp_err}); end
      n_vec++; if (data_samp_en !== 1'b0) begin n_err++; $display("FAIL reset_samp_en: got %b want 0", data_samp_en); end
      n_vec++; if (edge_cnt !== '0) begin n_err++; $display("FAIL reset_edge_cnt: got %0d want 0", edge_cnt); end
`ifdef UART_RX_ERR_CNT_EN
      n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
      RST = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_no_parity();
      got_q.delete(); max_run = 0;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL a5_valid_count: got %0d want 1", got_q.size()); end
      else begin n_vec++; if (got_q[0] !== 8'hA5) begin n_err++; $display("FAIL a5_byte: got %h want a5", got_q[0]); end end
      n_vec++; if (max_run != 1) begin n_err++; $display("FAIL a5_valid_width: got %0d want 1", max_run); end
      n_vec++; if ({par_err, stp_err} !== 2'b00) begin n_err++; $display("FAIL a5_flags: got %b want 00", {par_err, stp_err}); end
   endtask

   task automatic test_parity();
      got_q.delete();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
      model_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL par_bad_valid_count: got %0d want 0", got_q.size()); end
      n_vec++; if (par_err !== exp_par) begin n_err++; $display("FAIL par_bad_par_err: got %b want %b", par_err, exp_par); end
      n_vec++; if (P_DATA !== exp_pdata) begin n_err++; $display("FAIL par_bad_p_data_held: got %h want %h", P_DATA, exp_pdata); end
      got_q.delete();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
      model_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL par_good_valid_count: got %0d want 1", got_q.size()); end
      else begin n_vec++; if (got_q[0] !== 8'h3C) begin n_err++; $display("FAIL par_good_byte: got %h want 3c", got_q[0]); end end
      n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_good_par_err: got %b want 0", par_err); end
   endtask

   task automatic test_stop_err();
      got_q.delete();
      send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, 1'b0);
      model_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL stp_valid_count: got %0d want 0", got_q.size()); end
      n_vec++; if ({par_err, stp_err} !== {exp_par, exp_stp}) begin n_err++; $display("FAIL stp_flags: got %b want %b", {par_err, stp_err}, {exp_par, exp_stp}); end
      n_vec++; if (P_DATA !== exp_pdata) begin n_err++; $display("FAIL stp_p_data_held: got %h want %h", P_DATA, exp_pdata); end
      // Next good frame: stp_err must clear as soon as its start bit is seen.
      got_q.delete();
      Prescale = PRESCALE_32; cur_p = 32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
      drive_bit(1'b0, 16);
      n_vec++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL stp_clear_on_start: got %b want 0", stp_err); end
      n_vec++; if (data_samp_en !== 1'b1) begin n_err++; $display("FAIL start_samp_en: got %b want 1", data_samp_en); end
      n_vec++; if (edge_cnt !== PRESCALE_W'(15)) begin n_err++; $display("FAIL start_edge_cnt: got %0d want 15", edge_cnt); end
      drive_bit(1'b0, 16);
      drive_payload(8'h01, 32, 1'b1, 1'b0, 1'b1);
      model_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL after_stp_valid_count: got %0d want 1", got_q.size()); end
      else begin n_vec++; if (got_q[0] !== 8'h01) begin n_err++; $display("FAIL after_stp_byte: got %h want 01", got_q[0]); end end
   endtask

   task automatic test_glitch();
      got_q.delete();
      Prescale = PRESCALE_8; cur_p = 8; PAR_EN = 1'b0;
      drive_bit(1'b0, 2);
      drive_bit(1'b1, 20);
      if (exp_err_cnt < 255) exp_err_cnt = exp_err_cnt + 1;
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL glitch_valid_count: got %0d want 0", got_q.size()); end
      n_vec++; if ({par_err, stp_err} !== 2'b00) begin n_err++; $display("FAIL glitch_flags: got %b want 00", {par_err, stp_err}); end
      n_vec++; if (data_samp_en !== 1'b0) begin n_err++; $display("FAIL glitch_back_idle: got %b want 0", data_samp_en); end
`ifdef UART_RX_ERR_CNT_EN
      n_vec++; if (int'(err_cnt) != exp_err_cnt) begin n_err++; $display("FAIL glitch_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt); end
`endif
   endtask

   task automatic test_back_to_back();
      got_q.delete(); max_run = 0;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      model_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL b2b_valid_count: got %0d want 2", got_q.size()); end
      else begin
         n_vec++; if (got_q[0] !== 8'h55) begin n_err++; $display("FAIL b2b_first: got %h want 55", got_q[0]); end
         n_vec++; if (got_q[1] !== 8'hAA) begin n_err++; $display("FAIL b2b_second: got %h want aa", got_q[1]); end
      end
      n_vec++; if (max_run != 1) begin n_err++; $display("FAIL b2b_valid_width: got %0d want 1", max_run); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h12;
      got_q.delete();
      Prescale = PRESCALE_8; cur_p = 8; PAR_EN = 1'b0;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
      #2 RST = 1'b0;
      #1;
      exp_pdata = 8'h00; exp_err_cnt = 0;
      n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", data_valid); end
      n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL rst_mid_p_data: got %h want 00", P_DATA); end
      n_vec++; if (data_samp_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_samp_en: got %b want 0", data_samp_en); end
      n_vec++; if (edge_cnt !== '0) begin n_err++; $display("FAIL rst_mid_edge_cnt: got %0d want 0", edge_cnt); end
      n_vec++; if ({par_err, stp_err} !== 2'b00) begin n_err++; $display("FAIL rst_mid_flags: got %b want 00", {par_err, stp_err}); end
`ifdef UART_RX_ERR_CNT_EN
      n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_mid_err_cnt: got %0d want 0", err_cnt); end
`endif
      RX_IN = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      drive_bit(1'b1, 12);
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      model_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL rst_after_valid_count: got %0d want 1", got_q.size()); end
      else begin n_vec++; if (got_q[0] !== 8'h34) begin n_err++; $display("FAIL rst_after_byte: got %h want 34", got_q[0]); end end
   endtask

   task automatic test_random();
      int         p;
      logic [7:0] d;
      logic       pen, ptyp, pbit, stopb;
      max_run = 0;
      for (int n = 0; n < 40; n++) begin
         got_q.delete();
         p     = 8 << $urandom_range(0, 2);
         d     = 8'($urandom);
         pen   = 1'($urandom);
         ptyp  = 1'($urandom);
         pbit  = ((^d) ^ ptyp) ^ ($urandom_range(0, 4) == 0);
         stopb = ($urandom_range(0, 5) != 0);
         send_frame(d, p, pen, ptyp, pbit, stopb);
         model_frame(d, pen, ptyp, pbit, stopb);
         drive_bit(1'b1, 3);
         n_vec++; if (got_q.size() != (exp_good ? 1 : 0)) begin n_err++; $display("FAIL rnd%0d_valid_count: got %0d want %0d", n, got_q.size(), exp_good); end
         else if (exp_good) begin n_vec++; if (got_q[0] !== d) begin n_err++; $display("FAIL rnd%0d_byte: got %h want %h", n, got_q[0], d); end end
         n_vec++; if ({par_err, stp_err} !== {exp_par, exp_stp}) begin n_err++; $display("FAIL rnd%0d_flags: got %b want %b", n, {par_err, stp_err}, {exp_par, exp_stp}); end
         n_vec++; if (P_DATA !== exp_pdata) begin n_err++; $display("FAIL rnd%0d_p_data: got %h want %h", n, P_DATA, exp_pdata); end
`ifdef UART_RX_ERR_CNT_EN
         n_vec++; if (int'(err_cnt) != exp_err_cnt) begin n_err++; $display("FAIL rnd%0d_err_cnt: got %0d want %0d", n, err_cnt, exp_err_cnt); end
`endif
         drive_bit(1'b1, $urandom_range(0, 2));
      end
      n_vec++; if (max_run > 1) begin n_err++; $display("FAIL rnd_valid_width: got %0d want 1", max_run); end
   endtask

   initial begin
      test_reset();
      test_no_parity();
      test_parity();
      test_stop_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("modelled error events since last reset: %0d", exp_err_cnt);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
